// File: rtl/nn_pkg.sv
// Shared constants, forward-pass state type and saturating add for the output neuron stages.
package nn_pkg;

  localparam int HID_W = 10;
  localparam int W_W   = 8;
  localparam int ACC_W = 23;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } fwd_state_t;

  // Adds two unsigned values and clamps the result to 2^width-1; overflow flags the clamp.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned width,
                                          output logic overflow);
    logic [64:0] sum;
    logic [64:0] max_val;
    sum     = {1'b0, a} + {1'b0, b};
    max_val = (65'd1 << width) - 65'd1;
    overflow = (sum > max_val);
    if (overflow) begin
      return max_val[63:0];
    end
    return sum[63:0];
  endfunction

endpackage

// File: rtl/hidden_buf.sv
// Hidden activation register file: one synchronous write port, one combinational read port,
// synchronous clear. Out-of-range read indices return 0.
module hidden_buf #(
  parameter int N_ENTRIES = 4,
  parameter int DATA_W    = nn_pkg::HID_W,
  parameter int IDX_W     = 5
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [N_ENTRIES];
  logic [DATA_W-1:0] mem_d [N_ENTRIES];

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (we_i && (wr_idx_i == IDX_W'(i))) begin
        mem_d[i] = wr_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Decoded read keeps indices beyond N_ENTRIES from touching the array.
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (rd_idx_i == IDX_W'(i)) begin
        rd_data_o = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/output_forward_mac.sv
// Output neuron forward pass: sequential saturating MAC over hidden beats, with hidden buffer
// for backprop readback. Define OUTPUT_FWD_BIAS_EN to add a bias_i port that seeds the accumulator.
module output_forward_mac #(
  parameter int N_HIDDEN = 4,
  parameter int HID_W    = nn_pkg::HID_W,
  parameter int W_W      = nn_pkg::W_W,
  parameter int ACC_W    = nn_pkg::ACC_W,
  parameter int IDX_W    = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [HID_W-1:0] hidden_val_i,
  input  logic             hidden_valid_i,
  output logic             hidden_ready_o,
  output logic [IDX_W-1:0] w_idx_o,
  input  logic [W_W-1:0]   w_i,
`ifdef OUTPUT_FWD_BIAS_EN
  input  logic [W_W-1:0]   bias_i,
`endif
  output logic [ACC_W-1:0] final_o,
  output logic             final_valid_o,
  input  logic             final_ready_i,
  output logic             overflow_o,
  output logic             busy_o,
  input  logic [IDX_W-1:0] hid_rd_idx_i,
  output logic [HID_W-1:0] hid_rd_o
);
  import nn_pkg::*;

  localparam int PROD_W = HID_W + W_W;

  fwd_state_t        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              ovf_q, ovf_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  logic [PROD_W-1:0] product;
  logic [ACC_W-1:0]  mac_acc, init_acc;
  logic              mac_ovf, init_ovf;
  logic              beat;

  assign product = PROD_W'(hidden_val_i) * PROD_W'(w_i);
  assign beat    = (state_q == ACCUM) && hidden_valid_i;

  always_comb begin
    mac_ovf  = 1'b0;
    init_ovf = 1'b0;
    mac_acc  = ACC_W'(sat_add(64'(acc_q), 64'(product), ACC_W, mac_ovf));
`ifdef OUTPUT_FWD_BIAS_EN
    init_acc = ACC_W'(sat_add(64'd0, 64'(bias_i), ACC_W, init_ovf));
`else
    init_acc = '0;
`endif

    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ACCUM;
          acc_d   = init_acc;
          idx_d   = '0;
          ovf_d   = init_ovf;
        end
      end
      ACCUM: begin
        if (hidden_valid_i) begin
          acc_d = mac_acc;
          ovf_d = ovf_q | mac_ovf;
          // Index parks at 0 on the last beat so w_idx_o reads 0 outside ACCUM.
          if (idx_q == IDX_W'(N_HIDDEN - 1)) begin
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        if (final_ready_i) begin
          if (start_i) begin
            state_d = ACCUM;
            acc_d   = init_acc;
            idx_d   = '0;
            ovf_d   = init_ovf;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == ACCUM);
    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign hidden_ready_o = ready_q;
  assign final_valid_o  = valid_q;
  assign busy_o         = busy_q;
  assign overflow_o     = ovf_q;
  assign final_o        = acc_q;
  assign w_idx_o        = idx_q;

  hidden_buf #(
    .N_ENTRIES(N_HIDDEN),
    .DATA_W   (HID_W),
    .IDX_W    (IDX_W)
  ) u_hidden_buf (
    .clk_i    (clk_i),
    .clr_i    (rst_i),
    .we_i     (beat),
    .wr_idx_i (idx_q),
    .wr_data_i(hidden_val_i),
    .rd_idx_i (hid_rd_idx_i),
    .rd_data_o(hid_rd_o)
  );

endmodule

// File: tb/tb_output_forward_mac.sv
// Directed bench for output_forward_mac: default instance plus a 1-beat, 16-bit accumulator
// instance for saturation. Honours OUTPUT_FWD_BIAS_EN by adding the bias to expected sums.
module tb_output_forward_mac;

  localparam int HID_W = 10;
  localparam int W_W   = 8;
  localparam int ACC_W = 23;
  localparam int IDX_W = 5;
`ifdef OUTPUT_FWD_BIAS_EN
  localparam int BIAS = 5;
`else
  localparam int BIAS = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_i;
  logic             start_i, start16;
  logic [HID_W-1:0] hidden_val;
  logic             hidden_valid;
  logic             final_ready, final_ready16;
  logic [IDX_W-1:0] hid_rd_idx, hid_rd_idx16;
  logic [W_W-1:0]   bias;

  logic             hidden_ready, hidden_ready16;
  logic [IDX_W-1:0] w_idx, w_idx16;
  logic [W_W-1:0]   w, w16;
  logic [ACC_W-1:0] final_val;
  logic [15:0]      final16;
  logic             final_valid, final_valid16;
  logic             overflow, overflow16;
  logic             busy, busy16;
  logic [HID_W-1:0] hid_rd, hid_rd16;

  logic [W_W-1:0]   w_bank [32];
  logic [W_W-1:0]   w_bank16 [32];
  logic [HID_W-1:0] hv [4];

  int cycle = 0;
  int check_count = 0;
  int pass_count = 0;
  int fail_count = 0;
  int start_cycle;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  assign w   = w_bank[w_idx];
  assign w16 = w_bank16[w_idx16];

  output_forward_mac #(
    .N_HIDDEN(4), .HID_W(HID_W), .W_W(W_W), .ACC_W(ACC_W), .IDX_W(IDX_W)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .hidden_val_i(hidden_val), .hidden_valid_i(hidden_valid), .hidden_ready_o(hidden_ready),
    .w_idx_o(w_idx), .w_i(w),
`ifdef OUTPUT_FWD_BIAS_EN
    .bias_i(bias),
`endif
    .final_o(final_val), .final_valid_o(final_valid), .final_ready_i(final_ready),
    .overflow_o(overflow), .busy_o(busy),
    .hid_rd_idx_i(hid_rd_idx), .hid_rd_o(hid_rd)
  );

  output_forward_mac #(
    .N_HIDDEN(1), .HID_W(HID_W), .W_W(W_W), .ACC_W(16), .IDX_W(IDX_W)
  ) dut16 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start16),
    .hidden_val_i(hidden_val), .hidden_valid_i(hidden_valid), .hidden_ready_o(hidden_ready16),
    .w_idx_o(w_idx16), .w_i(w16),
`ifdef OUTPUT_FWD_BIAS_EN
    .bias_i(bias),
`endif
    .final_o(final16), .final_valid_o(final_valid16), .final_ready_i(final_ready16),
    .overflow_o(overflow16), .busy_o(busy16),
    .hid_rd_idx_i(hid_rd_idx16), .hid_rd_o(hid_rd16)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startPass();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Offers one beat after `gap` idle cycles; index must hold through the gap.
  task automatic applyStimulus(input logic [HID_W-1:0] val, input int gap, input int exp_idx, input string tag);
    hidden_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      tick();
      checkOutput({tag, " w_idx gap"}, 32'(w_idx), 32'(exp_idx));
    end
    checkOutput({tag, " ready"}, 32'(hidden_ready), 32'd1);
    checkOutput({tag, " w_idx"}, 32'(w_idx), 32'(exp_idx));
    checkOutput({tag, " valid early"}, 32'(final_valid), 32'd0);
    hidden_val   = val;
    hidden_valid = 1'b1;
    tick();
    hidden_valid = 1'b0;
  endtask

  task automatic runBeats(input int gap, input string tag);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(hv[k], gap, k, tag);
    end
  endtask

  task automatic ackResult(input string tag);
    final_ready = 1'b1;
    tick();
    final_ready = 1'b0;
    checkOutput({tag, " valid after ack"}, 32'(final_valid), 32'd0);
    checkOutput({tag, " busy after ack"}, 32'(busy), 32'd0);
  endtask

  task automatic setBasic();
    w_bank[0] = 8'd10; w_bank[1] = 8'd20; w_bank[2] = 8'd30; w_bank[3] = 8'd40;
    hv[0] = 10'd1; hv[1] = 10'd2; hv[2] = 10'd3; hv[3] = 10'd4;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; start16 = 1'b0;
    hidden_val = '0; hidden_valid = 1'b0;
    final_ready = 1'b0; final_ready16 = 1'b0;
    hid_rd_idx = '0; hid_rd_idx16 = '0;
    bias = W_W'(BIAS);
    for (int i = 0; i < 32; i++) begin
      w_bank[i] = '0;
      w_bank16[i] = '0;
    end

    // Reset state
    tick();
    tick();
    rst_i = 1'b0;
    checkOutput("reset valid", 32'(final_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset ready", 32'(hidden_ready), 32'd0);
    checkOutput("reset w_idx", 32'(w_idx), 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    checkOutput("reset final", 32'(final_val), 32'd0);
    checkOutput("reset hid_rd", 32'(hid_rd), 32'd0);

    // Basic sum, back-to-back beats
    setBasic();
    start_cycle = cycle;
    startPass();
    checkOutput("basic busy", 32'(busy), 32'd1);
    runBeats(0, "basic");
    checkOutput("basic valid", 32'(final_valid), 32'd1);
    checkOutput("basic latency", 32'(cycle - start_cycle), 32'd5);
    checkOutput("basic final", 32'(final_val), 32'(300 + BIAS));
    checkOutput("basic overflow", 32'(overflow), 32'd0);
    checkOutput("basic w_idx done", 32'(w_idx), 32'd0);
    ackResult("basic");

    // Max operands without overflow, then buffer readback
    for (int i = 0; i < 4; i++) begin
      w_bank[i] = 8'd255;
      hv[i] = 10'd1023;
    end
    startPass();
    runBeats(0, "max");
    checkOutput("max final", 32'(final_val), 32'(1043460 + BIAS));
    checkOutput("max overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) begin
      hid_rd_idx = IDX_W'(i);
      #1;
      checkOutput("max hid_rd", 32'(hid_rd), 32'd1023);
    end
    hid_rd_idx = 5'd7;
    #1;
    checkOutput("max hid_rd oob", 32'(hid_rd), 32'd0);
    hid_rd_idx = '0;
    ackResult("max");

    // Backpressure: 3 idle cycles before every beat, result held until acknowledged
    setBasic();
    startPass();
    runBeats(3, "bp");
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp valid held", 32'(final_valid), 32'd1);
      checkOutput("bp final held", 32'(final_val), 32'(300 + BIAS));
      tick();
    end
    checkOutput("bp valid before ack", 32'(final_valid), 32'd1);
    ackResult("bp");

    // Saturation on 16-bit accumulator, then restart clears overflow
    w_bank16[0] = 8'd255;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    checkOutput("sat ready", 32'(hidden_ready16), 32'd1);
    hidden_val = 10'd1023;
    hidden_valid = 1'b1;
    tick();
    hidden_valid = 1'b0;
    checkOutput("sat valid", 32'(final_valid16), 32'd1);
    checkOutput("sat final", 32'(final16), 32'd65535);
    checkOutput("sat overflow", 32'(overflow16), 32'd1);
    checkOutput("sat main idle", 32'(busy), 32'd0);
    final_ready16 = 1'b1;
    start16 = 1'b1;
    tick();
    final_ready16 = 1'b0;
    start16 = 1'b0;
    checkOutput("sat restart overflow", 32'(overflow16), 32'd0);
    checkOutput("sat restart valid", 32'(final_valid16), 32'd0);
    checkOutput("sat restart busy", 32'(busy16), 32'd1);
    hidden_val = 10'd1;
    hidden_valid = 1'b1;
    tick();
    hidden_valid = 1'b0;
    checkOutput("sat second final", 32'(final16), 32'(255 + BIAS));
    checkOutput("sat second overflow", 32'(overflow16), 32'd0);
    hid_rd_idx16 = '0;
    #1;
    checkOutput("sat hid_rd 0", 32'(hid_rd16), 32'd1);
    hid_rd_idx16 = 5'd1;
    #1;
    checkOutput("sat hid_rd oob", 32'(hid_rd16), 32'd0);
    final_ready16 = 1'b1;
    tick();
    final_ready16 = 1'b0;
    checkOutput("sat ack busy", 32'(busy16), 32'd0);

    // Reset mid-pass aborts with no output and clears the buffer
    setBasic();
    startPass();
    applyStimulus(hv[0], 0, 0, "rst");
    applyStimulus(hv[1], 0, 1, "rst");
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst ready", 32'(hidden_ready), 32'd0);
    checkOutput("rst w_idx", 32'(w_idx), 32'd0);
    checkOutput("rst final", 32'(final_val), 32'd0);
    hid_rd_idx = 5'd1;
    #1;
    checkOutput("rst hid_rd", 32'(hid_rd), 32'd0);
    hid_rd_idx = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst no valid", 32'(final_valid), 32'd0);
    end
    startPass();
    runBeats(0, "post rst");
    checkOutput("post rst final", 32'(final_val), 32'(300 + BIAS));
    checkOutput("post rst valid", 32'(final_valid), 32'd1);

    // Acknowledge and start in the same cycle: straight back to ACCUM with a fresh clear
    final_ready = 1'b1;
    start_i = 1'b1;
    tick();
    final_ready = 1'b0;
    start_i = 1'b0;
    checkOutput("chain valid", 32'(final_valid), 32'd0);
    checkOutput("chain busy", 32'(busy), 32'd1);
    checkOutput("chain final cleared", 32'(final_val), 32'(BIAS));
    runBeats(0, "chain");
    checkOutput("chain final", 32'(final_val), 32'(300 + BIAS));
    checkOutput("chain overflow", 32'(overflow), 32'd0);
    ackResult("chain");

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
